// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
package pipeline_ctrl_pkg;

    localparam int RW_DEFAULT = 5;
    localparam int CW_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL2 = 2'd1,
        FREEZE = 2'd2
    } state_t;

    // Bundle of the five pipeline control enables, most significant first.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_hold;
    } ctrl_t;

    // Canned control words for each kind of cycle the controller can issue.
    localparam ctrl_t CTRL_RUN    = 5'b11000;
    localparam ctrl_t CTRL_FLUSH  = 5'b11100;
    localparam ctrl_t CTRL_STALL  = 5'b00010;
    localparam ctrl_t CTRL_FREEZE = 5'b00001;
    localparam ctrl_t CTRL_RESET  = 5'b00110;

endpackage

// File: rtl/pipeline_ctrl_reg_match.sv
// Register-dependence detector: does the EX-stage destination feed either
// source operand of the instruction in ID. Register 0 is hardwired zero and
// therefore never creates a dependence.
module reg_match #(
    parameter int RW = 5
) (
    input  logic [RW-1:0] rd,
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rt,
    output logic          match
);

    // Pure compare; no state.
    assign match = (rd != '0) && ((rd == rs) || (rd == rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, taken-branch
// flush and memory-busy freeze. Outputs are decoded combinationally from the
// registered state and the current inputs.
// Optional saturating performance counters are enabled by PIPE_PERF_CNT_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// RUN    | normal issue; hazards detected and decoded here
// STALL2 | second stall cycle owed by a branch waiting on a load result
// FREEZE | data memory busy; back end held, ret says where to resume
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RW = RW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] ifid_rs,
    input  logic [RW-1:0] ifid_rt,
    input  logic [RW-1:0] idex_rd,
    input  logic          idex_mem_read,
    input  logic          idex_reg_write,
    input  logic          branch,
    input  logic          branch_taken,
    input  logic          mem_busy,
    output logic          pc_write,
    output logic          ifid_write,
    output logic          ifid_flush,
    output logic          idex_bubble,
    output logic          exmem_hold,
    output logic          stall
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt,
    output logic [CW-1:0] freeze_cnt
`endif
);

    logic   match;
    logic   load_use;
    logic   br_alu;
    logic   br_load;

    state_t state;
    state_t ret;
    state_t eff;
    state_t state_nxt;
    state_t ret_nxt;
    ctrl_t  ctrl;

    reg_match #(.RW(RW)) u_reg_match (
        .rd    (idex_rd),
        .rs    (ifid_rs),
        .rt    (ifid_rt),
        .match (match)
    );

    // Hazard classification of the instruction pair in ID/EX.
    always_comb begin
        load_use = idex_mem_read & match;
        br_alu   = branch & idex_reg_write & ~idex_mem_read & match;
        br_load  = branch & idex_mem_read & match;
    end

    // Decode the control word and next state. A FREEZE whose memory has
    // become ready behaves, in this same cycle, exactly like its return
    // state, so the decode works from that effective state.
    always_comb begin
        eff       = ((state == FREEZE) && !mem_busy) ? ret : state;
        ctrl      = CTRL_RUN;
        state_nxt = RUN;
        ret_nxt   = ret;
        case (eff)
            RUN: begin
                if (mem_busy) begin
                    ctrl      = CTRL_FREEZE;
                    state_nxt = FREEZE;
                    ret_nxt   = RUN;
                end else if (br_load) begin
                    ctrl      = CTRL_STALL;
                    state_nxt = STALL2;
                end else if (load_use || br_alu) begin
                    ctrl      = CTRL_STALL;
                    state_nxt = RUN;
                end else if (branch && branch_taken) begin
                    ctrl      = CTRL_FLUSH;
                    state_nxt = RUN;
                end else begin
                    ctrl      = CTRL_RUN;
                    state_nxt = RUN;
                end
            end
            STALL2: begin
                if (mem_busy) begin
                    // The owed stall is deferred until the freeze ends.
                    ctrl      = CTRL_FREEZE;
                    state_nxt = FREEZE;
                    ret_nxt   = STALL2;
                end else begin
                    ctrl      = CTRL_STALL;
                    state_nxt = RUN;
                end
            end
            FREEZE: begin
                // Only reachable with mem_busy still high.
                ctrl      = CTRL_FREEZE;
                state_nxt = FREEZE;
            end
            default: begin
                ctrl      = CTRL_RESET;
                state_nxt = RUN;
                ret_nxt   = RUN;
            end
        endcase
        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    // Register the controller state; reset drops any pending stall or freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            ret   <= RUN;
        end else begin
            state <= state_nxt;
            ret   <= ret_nxt;
        end
    end

    // Drive the individual enables from the decoded control word.
    always_comb begin
        pc_write    = ctrl.pc_write;
        ifid_write  = ctrl.ifid_write;
        ifid_flush  = ctrl.ifid_flush;
        idex_bubble = ctrl.idex_bubble;
        exmem_hold  = ctrl.exmem_hold;
        stall       = ~ctrl.pc_write;
    end

`ifdef PIPE_PERF_CNT_EN
    logic stall_ev;
    logic flush_ev;
    logic freeze_ev;

    // Events are qualified by reset so the forced reset outputs are not counted.
    always_comb begin
        stall_ev  = ~rst & ctrl.idex_bubble;
        flush_ev  = ~rst & ctrl.ifid_flush;
        freeze_ev = ~rst & ctrl.exmem_hold;
    end

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_ev && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (freeze_ev && (freeze_cnt != '1)) begin
                freeze_cnt <= freeze_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed hazard scenarios followed by random
// traffic, each cycle compared against a behavioural model that tracks only
// "stalls still owed" and "memory frozen".
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic [4:0] idex_rd;
    logic       idex_mem_read;
    logic       idex_reg_write;
    logic       branch;
    logic       branch_taken;
    logic       mem_busy;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       exmem_hold;
    logic       stall;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] freeze_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int m_owed   = 0;
    bit m_known  = 0;
    longint m_stl = 0;
    longint m_fl  = 0;
    longint m_frz = 0;

    pipeline_ctrl #(.RW(5), .CW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .idex_rd        (idex_rd),
        .idex_mem_read  (idex_mem_read),
        .idex_reg_write (idex_reg_write),
        .branch         (branch),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .exmem_hold     (exmem_hold),
        .stall          (stall)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .freeze_cnt     (freeze_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare mid-cycle, advance the model.
    // Expected word order: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}.
    task automatic cycle(input logic r, input logic busy, input logic br, input logic tk,
                         input logic mr, input logic rw,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        logic [4:0] e;
        bit         dep;
        rst = r; mem_busy = busy; branch = br; branch_taken = tk;
        idex_mem_read = mr; idex_reg_write = rw;
        idex_rd = rd; ifid_rs = rs; ifid_rt = rt;
        #3;
        dep = (rd != 0) && (rd == rs || rd == rt);
`ifdef PIPE_PERF_CNT_EN
        if (m_known) begin
            check("stall_cnt",  stall_cnt,  32'(m_stl));
            check("flush_cnt",  flush_cnt,  32'(m_fl));
            check("freeze_cnt", freeze_cnt, 32'(m_frz));
        end
`endif
        if (r) begin
            e = 5'b00110;
            m_owed = 0;
        end else if (busy) begin
            e = 5'b00001;
            m_frz++;
        end else if (m_owed > 0) begin
            e = 5'b00010;
            m_owed--;
            m_stl++;
        end else if (br && mr && dep) begin
            e = 5'b00010;
            m_owed = 1;
            m_stl++;
        end else if ((mr && dep) || (br && rw && !mr && dep)) begin
            e = 5'b00010;
            m_stl++;
        end else if (br && tk) begin
            e = 5'b11100;
            m_fl++;
        end else begin
            e = 5'b11000;
        end
        check("ctrl", 32'({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}), 32'(e));
        check("stall", 32'(stall), 32'(!e[4]));
        if (r) begin
            m_stl = 0; m_fl = 0; m_frz = 0; m_known = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
    endtask

    initial begin
        #1;
        cycle(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        cycle(1, 0, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3);
        idle(2);
        // load-use: one stall then run
        cycle(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd3);
        idle(2);
        // branch on load result: two stalls
        cycle(0, 0, 1, 0, 1, 1, 5'd7, 5'd1, 5'd7);
        idle(3);
        // branch on ALU result: one stall
        cycle(0, 0, 1, 1, 0, 1, 5'd4, 5'd4, 5'd1);
        idle(1);
        // register 0 never hazards
        cycle(0, 0, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        cycle(0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        // taken branch flush, and no flush while stalled
        cycle(0, 0, 1, 1, 0, 0, 5'd3, 5'd1, 5'd2);
        cycle(0, 0, 1, 1, 1, 1, 5'd2, 5'd2, 5'd1);
        cycle(0, 0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(1);
        // memory busy for three cycles during STALL2
        cycle(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        cycle(0, 0, 1, 0, 1, 1, 5'd6, 5'd6, 5'd1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(3);
        // memory busy from RUN
        cycle(0, 1, 1, 1, 1, 1, 5'd2, 5'd2, 5'd2);
        cycle(0, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        cycle(0, 0, 0, 0, 1, 1, 5'd2, 5'd2, 5'd2);
        idle(1);
        // reset pulsed in STALL2
        cycle(0, 0, 1, 0, 1, 1, 5'd7, 5'd7, 5'd1);
        cycle(1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(2);
        // random traffic over a small register range to provoke dependences
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99) == 0),
                  ($urandom_range(7) == 0),
                  ($urandom_range(2) == 0),
                  1'($urandom_range(1)),
                  ($urandom_range(2) == 0),
                  1'($urandom_range(1)),
                  5'($urandom_range(3)),
                  5'($urandom_range(3)),
                  5'($urandom_range(3)));
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
